key_schedule_ctrl: RTL and testbench



---
 rtl/key_schedule_ctrl_if.sv | 21 ++
 rtl/key_schedule_ctrl.sv | 161 ++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_ctrl_if.sv
// Key-source / round-engine side of the AES-128 key schedule sequencer.
// The master drives the key handshake and the read address; the slave is the sequencer.
interface key_schedule_ctrl_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic [3:0]   rk_rd_addr;
   logic [127:0] rk_rd_data;
   logic         keys_valid;
   logic         busy;

   modport master (
      output key_valid, key_in, rk_rd_addr,
      input  key_ready, rk_rd_data, keys_valid, busy
   );

   modport slave (
      input  key_valid, key_in, rk_rd_addr,
      output key_ready, rk_rd_data, keys_valid, busy
   );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule: a one-round-per-cycle expansion datapath plus the sequencer
// that loads it, feeds it Rcon, captures rk0..rk10 and serves them on a registered read port.

module key_expansion_logic (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_enable,
   input  logic [127:0] key_in,
   input  logic [31:0]  rcon_in,
   output logic [127:0] key_out
);
   logic [127:0] key_q;
   logic [31:0]  rot_word;
   logic [31:0]  temp_word;
   logic [31:0]  w0, w1, w2, w3;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box computed as GF(2^8) inverse (b^254, which maps 0 to 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign rot_word  = {key_q[23:0], key_q[31:24]};
   assign temp_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                       sbox(rot_word[15:8]),  sbox(rot_word[7:0])} ^ rcon_in;
   assign w0 = key_q[127:96] ^ temp_word;
   assign w1 = key_q[95:64]  ^ w0;
   assign w2 = key_q[63:32]  ^ w1;
   assign w3 = key_q[31:0]   ^ w2;

   assign key_out = key_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= '0;
      end else if (load_enable) begin
         key_q <= key_in;
      end else begin
         key_q <= {w0, w1, w2, w3};
      end
   end
endmodule

module key_schedule_ctrl (
   input logic               clk,
   input logic               rst,
   key_schedule_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] EXPAND = 2'd2;

   logic [1:0]   state;
   logic [3:0]   rnd;
   logic [7:0]   rcon_byte;
   logic [127:0] key_reg;
   logic         keys_valid_q;
   logic [127:0] rd_data_q;
   logic [127:0] rk_mem [0:10];
   logic         load_enable;
   logic [31:0]  rcon_in;
   logic [127:0] key_out;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   assign load_enable = (state == LOAD);
   assign rcon_in     = {rcon_byte, 24'h0};

   key_expansion_logic u_key_expansion (
      .clk         (clk),
      .rst         (rst),
      .load_enable (load_enable),
      .key_in      (key_reg),
      .rcon_in     (rcon_in),
      .key_out     (key_out)
   );

   // While rnd = r the datapath shows rk[r] and rcon_byte already holds rcon(r+1).
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rnd          <= 4'd0;
         rcon_byte    <= 8'h01;
         key_reg      <= '0;
         keys_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.key_valid) begin
                  key_reg      <= bus.key_in;
                  keys_valid_q <= 1'b0;
                  rcon_byte    <= 8'h01;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               rnd   <= 4'd0;
               state <= EXPAND;
            end
            EXPAND: begin
               if (rnd < 4'd10) begin
                  rnd       <= rnd + 4'd1;
                  rcon_byte <= xtime(rcon_byte);
               end else begin
                  keys_valid_q <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Round-key store has no reset; an aborted expansion leaves its partial writes behind.
   always_ff @(posedge clk) begin
      if (!rst && state == EXPAND && rnd <= 4'd10) begin
         rk_mem[rnd] <= key_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (bus.rk_rd_addr <= 4'd10) begin
         rd_data_q <= rk_mem[bus.rk_rd_addr];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign bus.key_ready  = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.keys_valid = keys_valid_q;
   assign bus.rk_rd_data = rd_data_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: a cycle-level reference model built from the
// AES-128 key expansion algorithm (table S-box), checked every cycle, plus FIPS-197 literals.
module tb_key_schedule_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_schedule_ctrl_if bus ();

   key_schedule_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C1_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] ZERO_KEY  = 128'h0;

   localparam logic [127:0] SBOX_ROWS [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [7:0] RCON_TAB [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
   };

   function automatic logic [7:0] sboxLookup(input logic [7:0] b);
      logic [127:0] row;
      int col;
      row = SBOX_ROWS[b[7:4]];
      col = int'(b[3:0]);
      return row[127 - 8*col -: 8];
   endfunction

   // Standard word-wise schedule step: round key r from round key r-1.
   function automatic logic [127:0] nextRoundKey(input logic [127:0] prev, input int r);
      logic [31:0] w [4];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = prev[127 - 32*i -: 32];
      t = {sboxLookup(w[3][23:16]), sboxLookup(w[3][15:8]),
           sboxLookup(w[3][7:0]),   sboxLookup(w[3][31:24])} ^ {RCON_TAB[r-1], 24'h0};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      return {w[0], w[1], w[2], w[3]};
   endfunction

   function automatic logic [127:0] roundKeyOf(input logic [127:0] key, input int r);
      logic [127:0] k;
      k = key;
      for (int i = 1; i <= r; i++) k = nextRoundKey(k, i);
      return k;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Reference model: phase counts edges since the accepting edge, -1 when idle.
   logic [127:0] sched [11];
   logic [127:0] mem [11];
   bit           memKnown [11];
   int           phase = -1;
   bit           expKv = 1'b0;
   logic [127:0] expRd = '0;
   bit           rdKnown = 1'b0;
   bit           modelReady = 1'b0;

   always @(posedge clk) begin : model
      int p;
      int a;
      logic [127:0] k;
      if (rst) begin
         phase      <= -1;
         expKv      <= 1'b0;
         expRd      <= '0;
         rdKnown    <= 1'b1;
         modelReady <= 1'b1;
      end else begin
         a = int'(bus.rk_rd_addr);
         if (a <= 10) begin
            expRd   <= mem[a];
            rdKnown <= memKnown[a];
         end else begin
            expRd   <= '0;
            rdKnown <= 1'b1;
         end
         p = phase;
         if (p == -1) begin
            if (bus.key_valid) begin
               phase <= 0;
               expKv <= 1'b0;
               k = bus.key_in;
               sched[0] <= k;
               for (int r = 1; r <= 10; r++) begin
                  k = nextRoundKey(k, r);
                  sched[r] <= k;
               end
            end
         end else begin
            p = p + 1;
            if (p >= 2) begin
               mem[p-2]      <= sched[p-2];
               memKnown[p-2] <= 1'b1;
            end
            if (p == 12) begin
               expKv <= 1'b1;
               phase <= -1;
            end else begin
               phase <= p;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("busy", bus.busy, phase >= 0);
         checkOutput("key_ready", bus.key_ready, phase < 0);
         checkOutput("keys_valid", bus.keys_valid, expKv);
         checkOutput("load_enable", dut.load_enable, phase == 0);
         if (rdKnown) checkOutput("rk_rd_data", bus.rk_rd_data, expRd);
         if (phase >= 1 && phase <= 10)
            checkOutput("rcon_in", dut.rcon_in[31:24], RCON_TAB[phase-1]);
      end
   end

   task automatic applyStimulus(input logic valid, input logic [127:0] key);
      bus.key_valid = valid;
      bus.key_in    = key;
   endtask

   // Presents a key, waits for keys_valid; cyc is the cycle index it appeared in.
   task automatic runKey(input logic [127:0] key, input bit holdOther,
                         output int cyc, output int loads);
      applyStimulus(1'b1, key);
      @(posedge clk); #1;
      if (holdOther) applyStimulus(1'b1, ~key);
      else applyStimulus(1'b0, key);
      cyc   = 1;
      loads = 0;
      while (cyc < 40) begin
         if (dut.load_enable) loads++;
         if (bus.keys_valid) break;
         @(posedge clk); #1;
         cyc++;
      end
      bus.key_valid = 1'b0;
   endtask

   task automatic readKey(input logic [3:0] addr, output logic [127:0] data);
      bus.rk_rd_addr = addr;
      @(posedge clk); #1;
      data = bus.rk_rd_data;
   endtask

   initial begin
      int cyc;
      int loads;
      logic [127:0] data;

      rst            = 1'b1;
      bus.key_valid  = 1'b1;
      bus.key_in     = FIPS_KEY;
      bus.rk_rd_addr = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.key_valid = 1'b0;
      checkOutput("reset_busy", bus.busy, 1'b0);
      checkOutput("reset_key_ready", bus.key_ready, 1'b1);
      checkOutput("reset_keys_valid", bus.keys_valid, 1'b0);
      checkOutput("reset_rd_data", bus.rk_rd_data, 128'h0);

      $display("[TB] FIPS-197 A.1 key expansion");
      runKey(FIPS_KEY, 1'b0, cyc, loads);
      checkOutput("fips_latency", cyc, 13);
      checkOutput("fips_load_pulses", loads, 1);
      readKey(4'd0, data);
      checkOutput("fips_rk0", data, FIPS_KEY);
      readKey(4'd1, data);
      checkOutput("fips_rk1", data, 128'ha0fafe1788542cb123a339392a6c7605);
      readKey(4'd10, data);
      checkOutput("fips_rk10", data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      for (int i = 0; i <= 10; i++) begin
         readKey(4'(i), data);
         checkOutput("fips_readback", data, roundKeyOf(FIPS_KEY, i));
      end

      $display("[TB] Different key held on key_valid while busy");
      runKey(C1_KEY, 1'b1, cyc, loads);
      checkOutput("hold_latency", cyc, 13);
      checkOutput("hold_load_pulses", loads, 1);
      readKey(4'd10, data);
      checkOutput("hold_rk10", data, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      $display("[TB] Back-to-back keys");
      runKey(FIPS_KEY, 1'b0, cyc, loads);
      checkOutput("b2b_first_latency", cyc, 13);
      applyStimulus(1'b1, ZERO_KEY);
      @(posedge clk); #1;
      applyStimulus(1'b0, ZERO_KEY);
      cyc = 14;
      checkOutput("b2b_kv_drop", bus.keys_valid, 1'b0);
      while (cyc < 60 && !bus.keys_valid) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("b2b_kv_rise_cycle", cyc, 26);
      readKey(4'd10, data);
      checkOutput("zero_rk10", data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      $display("[TB] Reset during expansion at rnd 5");
      applyStimulus(1'b1, FIPS_KEY);
      @(posedge clk); #1;
      applyStimulus(1'b0, FIPS_KEY);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("abort_busy_before", bus.busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort_busy", bus.busy, 1'b0);
      checkOutput("abort_keys_valid", bus.keys_valid, 1'b0);
      checkOutput("abort_key_ready", bus.key_ready, 1'b1);
      runKey(FIPS_KEY, 1'b0, cyc, loads);
      checkOutput("abort_latency", cyc, 13);
      readKey(4'd10, data);
      checkOutput("abort_rk10", data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      $display("[TB] Read port boundaries");
      readKey(4'd11, data);
      checkOutput("addr11_zero", data, 128'h0);
      readKey(4'd15, data);
      checkOutput("addr15_zero", data, 128'h0);
      for (int i = 0; i < 16; i++) begin
         bus.rk_rd_addr = 4'(15 - i);
         @(posedge clk); #1;
      end

      // rk3 is written at the edge ending cycle 5, so cycle 6 still shows the old key.
      bus.rk_rd_addr = 4'd3;
      applyStimulus(1'b1, ZERO_KEY);
      @(posedge clk); #1;
      applyStimulus(1'b0, ZERO_KEY);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rk3_old_during_write", bus.rk_rd_data, roundKeyOf(FIPS_KEY, 3));
      @(posedge clk); #1;
      checkOutput("rk3_new_after_write", bus.rk_rd_data, roundKeyOf(ZERO_KEY, 3));
      cyc = 7;
      while (cyc < 40 && !bus.keys_valid) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("rk3_run_latency", cyc, 13);

      $display("[TB] Idle stability");
      for (int i = 0; i < 100; i++) begin
         bus.rk_rd_addr = 4'(i % 11);
         @(posedge clk); #1;
      end
      checkOutput("idle_keys_valid", bus.keys_valid, 1'b1);
      readKey(4'd10, data);
      checkOutput("idle_rk10", data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      readKey(4'd0, data);
      checkOutput("idle_rk0", data, ZERO_KEY);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
